// File: rtl/nv_nvdla_mcif_rd_wrr_arb_if.sv
// Read-request handshake between MCIF read clients and the weighted round-robin arbiter.
// The master side drives requests, grant acceptance and retire pulses; the slave side is the arbiter.
interface nv_nvdla_mcif_rd_wrr_arb_if #(
  parameter int NUM_CLIENTS = 10,
  parameter int ID_W        = 4
);
  logic [NUM_CLIENTS-1:0] req;
  logic                   gnt_valid;
  logic [ID_W-1:0]        gnt_id;
  logic                   gnt_ready;
  logic                   rd_done;

  modport master (output req, gnt_ready, rd_done, input gnt_valid, gnt_id);
  modport slave  (input req, gnt_ready, rd_done, output gnt_valid, gnt_id);
endinterface

// File: rtl/nv_nvdla_mcif_rd_wrr_arb.sv
// Weighted round-robin MCIF read arbiter with an outstanding-read throttle and idle/underflow status.
// Optional NVDLA_MCIF_RD_ARB_PERF_EN adds a saturating counter of cycles stalled by the outstanding limit.
module nv_nvdla_mcif_rd_wrr_arb #(
  parameter int NUM_CLIENTS = 10,
  parameter int ID_W        = 4
) (
  input  logic                       nvdla_core_clk,
  input  logic                       nvdla_core_rst,
  nv_nvdla_mcif_rd_wrr_arb_if.slave  rd_if,
  input  logic [NUM_CLIENTS*8-1:0]   rd_weight,
  input  logic [7:0]                 rd_os_cnt,
  output logic [8:0]                 os_cnt,
  output logic                       idle,
  output logic                       os_underflow
`ifdef NVDLA_MCIF_RD_ARB_PERF_EN
  ,
  input  logic                       perf_clr,
  output logic [31:0]                perf_os_stall
`endif
);

  typedef enum logic [1:0] {ST_REFILL, ST_ARB, ST_GNT} state_t;

  state_t                 r_state, w_state_nxt;
  logic [7:0]             r_credit [NUM_CLIENTS];
  logic [ID_W-1:0]        r_ptr, r_gnt_id, w_winner;
  logic                   r_gnt_valid;
  logic [8:0]             r_os_cnt;
  logic                   r_underflow;
  logic [NUM_CLIENTS-1:0] w_eligible;
  logic                   w_found, w_grant, w_accept, w_issue_ok;

  function automatic logic [ID_W-1:0] wrap_idx(input logic [ID_W-1:0] base, input int unsigned off);
    logic [ID_W:0] sum;
    sum = {1'b0, base} + (ID_W+1)'(off);
    if (sum >= (ID_W+1)'(NUM_CLIENTS)) sum = sum - (ID_W+1)'(NUM_CLIENTS);
    return sum[ID_W-1:0];
  endfunction

  assign w_accept   = r_gnt_valid & rd_if.gnt_ready;
  // Pending is zero in ARB today, but keeps the limit exact if grant and arbitration ever overlap.
  assign w_issue_ok = ({1'b0, r_os_cnt} + {9'd0, w_accept}) < ({2'b00, rd_os_cnt} + 10'd1);

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    w_eligible = '0;
    for (int i = 0; i < NUM_CLIENTS; i++) begin
      w_eligible[i] = rd_if.req[i] & (r_credit[i] != 8'd0);
    end
  end

  always_comb begin
    w_found  = 1'b0;
    w_winner = '0;
    for (int k = 1; k <= NUM_CLIENTS; k++) begin
      if (!w_found && w_eligible[wrap_idx(r_ptr, k)]) begin
        w_found  = 1'b1;
        w_winner = wrap_idx(r_ptr, k);
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_grant     = 1'b0;
    unique case (r_state)
      ST_REFILL: w_state_nxt = ST_ARB;
      ST_ARB: begin
        if (w_found && w_issue_ok) begin
          w_grant     = 1'b1;
          w_state_nxt = ST_GNT;
        end else if (!w_found && (rd_if.req != '0)) begin
          w_state_nxt = ST_REFILL;
        end
      end
      ST_GNT:  if (w_accept) w_state_nxt = ST_ARB;
      default: w_state_nxt = ST_REFILL;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge nvdla_core_clk) begin
    if (nvdla_core_rst) begin
      r_state     <= ST_REFILL;
      r_ptr       <= ID_W'(NUM_CLIENTS - 1);
      r_gnt_valid <= 1'b0;
      r_gnt_id    <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_grant) begin
        r_gnt_valid <= 1'b1;
        r_gnt_id    <= w_winner;
        r_ptr       <= w_winner;
      end else if (w_accept) begin
        r_gnt_valid <= 1'b0;
      end
    end
  end

  // NOTE: the credit array is a small flop bank whose cleared state matters, so it is reset, unlike a RAM.
  always_ff @(posedge nvdla_core_clk) begin
    if (nvdla_core_rst) begin
      for (int i = 0; i < NUM_CLIENTS; i++) r_credit[i] <= 8'd0;
    end else if (r_state == ST_REFILL) begin
      for (int i = 0; i < NUM_CLIENTS; i++) begin
        r_credit[i] <= (rd_weight[8*i +: 8] == 8'd0) ? 8'd1 : rd_weight[8*i +: 8];
      end
    end else if (w_accept) begin
      r_credit[r_gnt_id] <= r_credit[r_gnt_id] - 8'd1;
    end
  end

  always_ff @(posedge nvdla_core_clk) begin
    if (nvdla_core_rst) begin
      r_os_cnt    <= 9'd0;
      r_underflow <= 1'b0;
    end else begin
      unique case ({w_accept, rd_if.rd_done})
        2'b10: if (r_os_cnt != 9'd256) r_os_cnt <= r_os_cnt + 9'd1;
        2'b01: begin
          if (r_os_cnt == 9'd0) r_underflow <= 1'b1;
          else                  r_os_cnt    <= r_os_cnt - 9'd1;
        end
        default: ;
      endcase
    end
  end

`ifdef NVDLA_MCIF_RD_ARB_PERF_EN
  logic [31:0] r_perf_os_stall;
  logic        w_stall;

  assign w_stall = (r_state == ST_ARB) & w_found & ~w_issue_ok;

  always_ff @(posedge nvdla_core_clk) begin
    if (nvdla_core_rst || perf_clr) r_perf_os_stall <= 32'd0;
    else if (w_stall && (r_perf_os_stall != 32'hFFFF_FFFF))
      r_perf_os_stall <= r_perf_os_stall + 32'd1;
  end

  assign perf_os_stall = r_perf_os_stall;
`endif

  assign rd_if.gnt_valid = r_gnt_valid;
  assign rd_if.gnt_id    = r_gnt_id;
  assign os_cnt          = r_os_cnt;
  assign os_underflow    = r_underflow;
  assign idle            = (r_os_cnt == 9'd0) & ~r_gnt_valid & (rd_if.req == '0);

endmodule

// File: tb/tb_nv_nvdla_mcif_rd_wrr_arb.sv
// Directed bench for the MCIF read WRR arbiter: rotation, weights, outstanding throttle, handshake hold,
// underflow/idle status and, when NVDLA_MCIF_RD_ARB_PERF_EN is defined, the stall counter.
module tb_nv_nvdla_mcif_rd_wrr_arb;
  localparam int NC = 10;
  localparam int IW = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [NC*8-1:0] rd_weight;
  logic [7:0]    rd_os_cnt;
  logic [8:0]    os_cnt;
  logic          idle;
  logic          os_underflow;
`ifdef NVDLA_MCIF_RD_ARB_PERF_EN
  logic          perf_clr;
  logic [31:0]   perf_os_stall;
`endif

  int n_total = 0;
  int n_bad   = 0;

  nv_nvdla_mcif_rd_wrr_arb_if #(.NUM_CLIENTS(NC), .ID_W(IW)) rd_if ();

  nv_nvdla_mcif_rd_wrr_arb #(.NUM_CLIENTS(NC), .ID_W(IW)) dut (
    .nvdla_core_clk (clk),
    .nvdla_core_rst (rst),
    .rd_if          (rd_if),
    .rd_weight      (rd_weight),
    .rd_os_cnt      (rd_os_cnt),
    .os_cnt         (os_cnt),
    .idle           (idle),
    .os_underflow   (os_underflow)
`ifdef NVDLA_MCIF_RD_ARB_PERF_EN
    ,
    .perf_clr       (perf_clr),
    .perf_os_stall  (perf_os_stall)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic set_weights(input logic [7:0] w);
    for (int i = 0; i < NC; i++) rd_weight[8*i +: 8] = w;
  endtask

  // Waits (bounded) for gnt_valid; optionally spends one more edge so a ready=1 grant is accepted.
  task automatic next_grant(input bit accept, output logic [IW-1:0] id, output int waited);
    waited = 0;
    while (rd_if.gnt_valid !== 1'b1 && waited < 20) begin
      tick();
      waited++;
    end
    id = rd_if.gnt_id;
    if (accept) tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [IW-1:0] id;
    int            w;
    int            cnt;
    int            exp_id1 [4] = '{0, 1, 0, 1};
    int            exp_w1  [4] = '{2, 1, 3, 1};
    int            exp_id2 [12] = '{0, 1, 0, 0, 1, 0, 0, 0, 1, 0, 0, 0};
    int            exp_w2  [12] = '{2, 1, 1, 1, 3, 1, 1, 1, 3, 1, 1, 1};

    rd_if.req       = '0;
    rd_if.gnt_ready = 1'b1;
    rd_if.rd_done   = 1'b0;
    rd_os_cnt       = 8'd255;
    set_weights(8'd1);
`ifdef NVDLA_MCIF_RD_ARB_PERF_EN
    perf_clr = 1'b0;
`endif

    // Reset values
    do_reset();
    check("rst_gnt_valid", rd_if.gnt_valid, 0);
    check("rst_gnt_id", rd_if.gnt_id, 0);
    check("rst_os_cnt", os_cnt, 0);
    check("rst_underflow", os_underflow, 0);
    check("rst_idle", idle, 1);

    // Two clients, unit weights: alternate with a refill bubble after every pair
    rd_if.req = 10'h003;
    do_reset();
    for (int g = 0; g < 4; g++) begin
      next_grant(1'b1, id, w);
      check($sformatf("rr_id%0d", g), id, exp_id1[g]);
      check($sformatf("rr_wait%0d", g), w, exp_w1[g]);
    end
    check("rr_os_cnt", os_cnt, 4);
    check("rr_idle", idle, 0);

    // Weights 3:1; the pointer carries over so later windows start after client 0
    rd_weight[7:0] = 8'd3;
    do_reset();
    for (int g = 0; g < 12; g++) begin
      next_grant(1'b1, id, w);
      check($sformatf("wrr_id%0d", g), id, exp_id2[g]);
      check($sformatf("wrr_wait%0d", g), w, exp_w2[g]);
    end

    // Outstanding limit of 2
    set_weights(8'd1);
    rd_os_cnt = 8'd1;
    rd_if.req = 10'h001;
    do_reset();
    next_grant(1'b1, id, w);
    check("os_g0_wait", w, 2);
    next_grant(1'b1, id, w);
    check("os_g1_wait", w, 3);
    check("os_cnt_full", os_cnt, 2);
    cnt = 0;
    for (int c = 0; c < 10; c++) begin
      tick();
      if (rd_if.gnt_valid === 1'b1) cnt++;
    end
    check("os_blocked_grants", cnt, 0);
    check("os_cnt_held", os_cnt, 2);
    rd_if.rd_done = 1'b1;
    tick();
    rd_if.rd_done = 1'b0;
    check("os_after_done", os_cnt, 1);
    next_grant(1'b1, id, w);
    check("os_regrant_wait", w, 1);
    check("os_regrant_id", id, 0);
    check("os_cnt_refull", os_cnt, 2);
    cnt = 0;
    for (int c = 0; c < 10; c++) begin
      tick();
      if (rd_if.gnt_valid === 1'b1) cnt++;
    end
    check("os_only_one_more", cnt, 0);

    // Grant held while ready is low; accept coincident with rd_done
    rd_os_cnt = 8'd255;
    do_reset();
    next_grant(1'b1, id, w);
    check("hold_first_wait", w, 2);
    rd_if.gnt_ready = 1'b0;
    next_grant(1'b0, id, w);
    check("hold_wait", w, 3);
    for (int c = 0; c < 5; c++) begin
      tick();
      check($sformatf("hold_valid%0d", c), rd_if.gnt_valid, 1);
      check($sformatf("hold_id%0d", c), rd_if.gnt_id, 0);
      check($sformatf("hold_os%0d", c), os_cnt, 1);
    end
    rd_if.gnt_ready = 1'b1;
    rd_if.rd_done   = 1'b1;
    tick();
    rd_if.rd_done   = 1'b0;
    check("acc_done_os", os_cnt, 1);
    check("acc_done_valid", rd_if.gnt_valid, 0);
    check("acc_done_underflow", os_underflow, 0);

    // Reset while a grant is waiting drops it uncounted
    rd_if.gnt_ready = 1'b0;
    next_grant(1'b0, id, w);
    check("midrst_wait", w, 3);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("midrst_valid", rd_if.gnt_valid, 0);
    check("midrst_os", os_cnt, 0);
    rd_if.gnt_ready = 1'b1;

    // Underflow is sticky; idle with nothing pending
    rd_if.req = '0;
    do_reset();
    rd_if.rd_done = 1'b1;
    tick();
    rd_if.rd_done = 1'b0;
    check("uf_os", os_cnt, 0);
    check("uf_flag", os_underflow, 1);
    tick();
    tick();
    tick();
    check("uf_sticky", os_underflow, 1);
    check("uf_idle", idle, 1);
    do_reset();
    check("uf_cleared", os_underflow, 0);

    // Weight 0 behaves as 1: one grant per refill window
    rd_weight[23:16] = 8'd0;
    rd_if.req = 10'h004;
    do_reset();
    for (int g = 0; g < 3; g++) begin
      next_grant(1'b1, id, w);
      check($sformatf("w0_id%0d", g), id, 2);
      check($sformatf("w0_wait%0d", g), w, (g == 0) ? 2 : 3);
    end

`ifdef NVDLA_MCIF_RD_ARB_PERF_EN
    // Stall counter: limit 1 in flight, one read outstanding, client 0 keeps asking
    set_weights(8'd1);
    rd_os_cnt = 8'd0;
    rd_if.req = 10'h001;
    do_reset();
    check("perf_rst", perf_os_stall, 0);
    next_grant(1'b1, id, w);
    check("perf_os", os_cnt, 1);
    tick();
    tick();
    perf_clr = 1'b1;
    tick();
    perf_clr = 1'b0;
    check("perf_clr_wins", perf_os_stall, 0);
    for (int c = 0; c < 10; c++) tick();
    check("perf_10", perf_os_stall, 10);
    check("perf_no_grant", rd_if.gnt_valid, 0);
    perf_clr = 1'b1;
    tick();
    perf_clr = 1'b0;
    check("perf_cleared", perf_os_stall, 0);
`endif

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end
endmodule
